// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access.
// One access in flight; fetch/data alternate under contention.
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_func,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        dm_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);
  localparam logic [2:0] FN_WORD = 3'b010;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic        r_last_d;
  logic        r_own_d;
  logic        r_we;
  logic        r_flush;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_func;
  logic [31:0] r_cap;

  logic        w_dreq;
  logic        w_any;
  logic        w_gnt_d;
  logic        w_idle;

  assign w_dreq  = dm_rd | dm_wr;
  assign w_any   = w_dreq | if_req;
  assign w_gnt_d = w_dreq & ~(r_last_d & if_req);
  assign w_idle  = (r_state == S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state: grant from IDLE, count down in BUSY, one DONE cycle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_any) w_next = S_BUSY;
      S_BUSY: if (r_cnt == 2'd0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant latches, latency counter, flush marker and read capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 2'd0;
      r_last_d <= 1'b0;
      r_own_d  <= 1'b0;
      r_we     <= 1'b0;
      r_flush  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_func   <= '0;
      r_cap    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_own_d  <= w_gnt_d;
            r_last_d <= w_gnt_d;
            r_we     <= w_gnt_d & dm_wr;
            r_addr   <= w_gnt_d ? dm_addr : if_addr;
            r_wdata  <= w_gnt_d ? dm_wdata : 32'd0;
            r_func   <= w_gnt_d ? dm_func : FN_WORD;
            r_cnt    <= LAT_M1;
            r_flush  <= 1'b0;
          end
        end
        S_BUSY: begin
          if (r_cnt == 2'd0) r_cap <= mem_rdata;
          else               r_cnt <= r_cnt - 2'd1;
          if (!r_own_d && if_flush) r_flush <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (r_state == S_BUSY);
  assign mem_we    = (r_state == S_BUSY) & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_func  = r_func;

  assign if_valid = (r_state == S_DONE) & ~r_own_d
                  & ~r_flush & ~if_flush;
  assign dm_valid = (r_state == S_DONE) & r_own_d;
  assign if_rdata = r_cap;
  assign dm_rdata = r_cap;

  assign dm_err = rst & w_idle & w_gnt_d & dm_rd & dm_wr;

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = w_dreq & ~dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 2 and 1) on shared stimulus,
// compared every cycle against a transaction-age reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_func;
  logic [31:0] mem_rdata;

  logic [31:0] a_ifr, a_dmr, a_ma, a_mw;
  logic [2:0]  a_mf;
  logic        a_ifv, a_ifs, a_dmv, a_dms, a_err, a_en, a_we;
  logic [31:0] b_ifr, b_dmr, b_ma, b_mw;
  logic [2:0]  b_mf;
  logic        b_ifv, b_ifs, b_dmv, b_dms, b_err, b_en, b_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(a_ifr), .if_valid(a_ifv), .if_stall(a_ifs),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_func(dm_func),
    .dm_rdata(a_dmr), .dm_valid(a_dmv), .dm_stall(a_dms),
    .dm_err(a_err), .mem_en(a_en), .mem_we(a_we),
    .mem_addr(a_ma), .mem_wdata(a_mw), .mem_func(a_mf),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(b_ifr), .if_valid(b_ifv), .if_stall(b_ifs),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_func(dm_func),
    .dm_rdata(b_dmr), .dm_valid(b_dmv), .dm_stall(b_dms),
    .dm_err(b_err), .mem_en(b_en), .mem_we(b_we),
    .mem_addr(b_ma), .mem_wdata(b_mw), .mem_func(b_mf),
    .mem_rdata(mem_rdata)
  );

  // Reference model: age = cycles since grant (0 = no access)
  int          m_age[2];
  logic        m_own_d[2];
  logic        m_we[2];
  logic        m_fl[2];
  logic        m_last_d[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wd[2];
  logic [31:0] m_cap[2];
  logic [2:0]  m_fn[2];
  int          valid_seen[2];

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_age[d]    = 0;
      m_own_d[d]  = 1'b0;
      m_we[d]     = 1'b0;
      m_fl[d]     = 1'b0;
      m_last_d[d] = 1'b0;
      m_addr[d]   = '0;
      m_wd[d]     = '0;
      m_cap[d]    = '0;
      m_fn[d]     = '0;
    end
  endtask

  function automatic logic pick_data(input int d);
    return (dm_rd | dm_wr) & ~(m_last_d[d] & if_req);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d,
      input logic [31:0] ifr, input logic [31:0] dmr,
      input logic [31:0] ma, input logic [31:0] mw,
      input logic [2:0] mf, input logic ifv, input logic ifs,
      input logic dmv, input logic dms, input logic err,
      input logic en, input logic we);
    logic busy, done, e_ifv, e_dmv, e_err;
    string p;
    p = (d == 0) ? "L2" : "L1";
    if (!rst) m_reset();
    busy  = (m_age[d] >= 1) && (m_age[d] <= lat(d));
    done  = (m_age[d] == lat(d) + 1);
    e_ifv = done & ~m_own_d[d] & ~m_fl[d] & ~if_flush;
    e_dmv = done & m_own_d[d];
    e_err = rst & (m_age[d] == 0) & pick_data(d) & dm_rd & dm_wr;
    chk({p, ".mem_en"}, 32'(en), 32'(busy));
    chk({p, ".mem_we"}, 32'(we), 32'(busy & m_we[d]));
    chk({p, ".mem_addr"}, ma, m_addr[d]);
    chk({p, ".mem_wdata"}, mw, m_wd[d]);
    chk({p, ".mem_func"}, 32'(mf), 32'(m_fn[d]));
    chk({p, ".if_valid"}, 32'(ifv), 32'(e_ifv));
    chk({p, ".dm_valid"}, 32'(dmv), 32'(e_dmv));
    chk({p, ".dm_err"}, 32'(err), 32'(e_err));
    chk({p, ".if_stall"}, 32'(ifs), 32'(if_req & ~e_ifv));
    chk({p, ".dm_stall"}, 32'(dms), 32'((dm_rd | dm_wr) & ~e_dmv));
    if (e_ifv) chk({p, ".if_rdata"}, ifr, m_cap[d]);
    if (e_dmv) chk({p, ".dm_rdata"}, dmr, m_cap[d]);
    if (e_ifv | e_dmv) valid_seen[d]++;
  endtask

  task automatic m_step();
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_reset();
      end else if (m_age[d] == 0) begin
        if (if_req | dm_rd | dm_wr) begin
          m_own_d[d]  = pick_data(d);
          m_last_d[d] = m_own_d[d];
          m_we[d]     = m_own_d[d] & dm_wr;
          m_addr[d]   = m_own_d[d] ? dm_addr : if_addr;
          m_wd[d]     = m_own_d[d] ? dm_wdata : 32'd0;
          m_fn[d]     = m_own_d[d] ? dm_func : 3'b010;
          m_fl[d]     = 1'b0;
          m_age[d]    = 1;
        end
      end else if (m_age[d] <= lat(d)) begin
        if (!m_own_d[d] && if_flush) m_fl[d] = 1'b1;
        if (m_age[d] == lat(d)) m_cap[d] = mem_rdata;
        m_age[d]++;
      end else begin
        m_age[d] = 0;
      end
    end
  endtask

  // One clock: inputs applied after the edge, outputs checked mid-cycle
  task automatic cyc(input logic r, input logic ir,
                     input logic [31:0] ia, input logic fl,
                     input logic rd, input logic wr,
                     input logic [31:0] da, input logic [31:0] wd,
                     input logic [2:0] fn);
    rst       = r;
    if_req    = ir;
    if_addr   = ia;
    if_flush  = fl;
    dm_rd     = rd;
    dm_wr     = wr;
    dm_addr   = da;
    dm_wdata  = wd;
    dm_func   = fn;
    mem_rdata = $urandom;
    #3;
    check_dut(0, a_ifr, a_dmr, a_ma, a_mw, a_mf,
              a_ifv, a_ifs, a_dmv, a_dms, a_err, a_en, a_we);
    check_dut(1, b_ifr, b_dmr, b_ma, b_mw, b_mf,
              b_ifv, b_ifs, b_dmv, b_dms, b_err, b_en, b_we);
    @(posedge clk);
    m_step();
    #1;
  endtask

  initial begin
    m_reset();
    valid_seen[0] = 0;
    valid_seen[1] = 0;
    rst = 1'b0;
    if_req = 0; if_addr = 0; if_flush = 0;
    dm_rd = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0; dm_func = 0;
    mem_rdata = 0;
    @(posedge clk);
    #1;
    // reset held with requests present: outputs quiet, stalls follow inputs
    cyc(0, 1, 32'h40, 0, 1, 1, 32'h44, 32'h1, 3'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // single fetch at 0x10
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 32'h10, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("fetch_done_L2", valid_seen[0], 1);
    // fetch and load together, last grant was fetch
    for (int i = 0; i < 8; i++)
      cyc(1, 1, 32'h14, 0, 1, 0, 32'h100, 0, 3'd2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // continuous store plus fetch: alternation
    for (int i = 0; i < 12; i++)
      cyc(1, 1, 32'h18, 0, 0, 1, 32'h200, 32'hA5A5_0000 + 32'(i), 3'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // flush during fetch BUSY
    cyc(1, 1, 32'h1C, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h1C, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(1, 1, 32'h80, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // conflicting read+write
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 0, 0, 1, 1, 32'h20, 32'hDEAD_BEEF, 3'd2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of a fetch
    cyc(1, 1, 32'h30, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h30, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h30, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 63) != 0),
          1'($urandom), $urandom, ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
          $urandom, $urandom, 3'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, 2, memory access latency in cycles; legal range 1..4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  instruction fetch request; held high until if_valid.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_flush  input  1  discard the in-flight fetch (taken branch/jump).
REQ-007 if_rdata  output  32  fetched instruction; meaningful only while if_valid=1.
REQ-008 if_valid  output  1  one-cycle fetch completion pulse.
REQ-009 if_stall  output  1  fetch stage must hold PC and IF_ID.
REQ-010 dm_rd  input  1  data read request from MEM stage.
REQ-011 dm_wr  input  1  data write request from MEM stage.
REQ-012 dm_addr  input  32  data byte address.
REQ-013 dm_wdata  input  32  store data.
REQ-014 dm_func  input  3  funct3 access size/sign code, passed to memory.
REQ-015 dm_rdata  output  32  load data; meaningful only while dm_valid=1.
REQ-016 dm_valid  output  1  one-cycle data-access completion pulse (reads and writes).
REQ-017 dm_stall  output  1  pipeline must hold all stages up to and including EX_MEM.
REQ-018 dm_err  output  1  one-cycle pulse: dm_rd and dm_wr both high when sampled.
REQ-019 mem_en, mem_we  output  1 each  single-port memory enable/write-enable.
REQ-020 mem_addr, mem_wdata  output  32 each; mem_func  output  3  latched request fields.
REQ-021 mem_rdata  input  32  memory read data, valid on the last BUSY cycle.

Function
REQ-022 FSM SHALL have states IDLE, BUSY, DONE; at most one access in flight.
REQ-023 IDLE: if any request pending, SHALL grant one, latch addr/wdata/func/we and owner, load cnt=MEM_LAT-1, go BUSY.
REQ-024 Arbitration: grant data unless last_grant=DATA and if_req=1, in which case grant fetch; last_grant updates on every grant.
REQ-025 BUSY: mem_en=1, mem_we=latched we, mem_* driven from latches; cnt decrements; at cnt=0 go DONE and capture mem_rdata.
REQ-026 DONE: owner's valid=1 for exactly one cycle, rdata from capture register; SHALL return to IDLE, no grant in DONE.
REQ-027 Latency: request sampled in IDLE at cycle N; BUSY cycles N+1..N+MEM_LAT; valid at cycle N+MEM_LAT+1.
REQ-028 if_stall = if_req & ~if_valid; dm_stall = (dm_rd|dm_wr) & ~dm_valid; both combinational.
REQ-029 mem_en=0, mem_we=0 in IDLE and DONE; memory outputs SHALL not change during BUSY.
REQ-030 dm_rd=dm_wr=1 at grant: SHALL perform write, pulse dm_err in the same cycle as the grant.
REQ-031 if_flush while fetch owns BUSY or DONE: access completes on memory, if_valid SHALL stay 0 for it; flush in IDLE has no effect.
REQ-032 Request dropped before valid (other than flush): access completes, valid still pulses; no error.
REQ-033 MEM_LAT=1: exactly one BUSY cycle; cnt SHALL be 2 bits, no wrap below 0.

Reset
REQ-034 rst low SHALL immediately force state=IDLE, cnt=0, last_grant=FETCH, all latches and capture register 0, all outputs 0 except combinational stalls.
REQ-035 rst asserted mid-access SHALL abandon the access; no valid pulse after release; first grant after release follows REQ-024.

Verification
REQ-036 MEM_LAT=2, if_req=1 at cycle 0, addr 0x10 -> mem_en cycles 1-2, if_valid cycle 3 with mem_rdata of cycle 2, if_stall high cycles 0-2.
REQ-037 if_req and dm_rd both high at IDLE, last_grant=FETCH -> data granted first; fetch granted in next IDLE; dm_valid then if_valid, 4 cycles apart.
REQ-038 Continuous dm_wr and if_req -> grants alternate DATA, FETCH, DATA; mem_we=1 only in data BUSY cycles.
REQ-039 if_flush pulse during fetch BUSY -> memory cycle completes, if_valid never asserted for that fetch, next request granted normally.
REQ-040 dm_rd=dm_wr=1 addr 0x20 wdata 0xDEADBEEF -> dm_err pulse at grant, write performed, dm_valid pulses.
REQ-041 rst low during BUSY -> all outputs 0 asynchronously, no valid after release; MEM_LAT=1 run repeats REQ-036 with valid at cycle 2.
